// File: rtl/tag_fifo_pkg.sv
// rtl/tag_fifo_pkg.sv - shared constants, entry type and helpers for tag_fifo
package tag_fifo_pkg;

  localparam int UPR_VALID_BIT = 4;
  localparam int DEF_TAG_W     = 3;
  localparam int DEF_DATA_W    = 8;
  localparam int DROP_CNT_W    = 8;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tag_fifo_mem.sv
// rtl/tag_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read port
module tag_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Storage is deliberately left unreset; validity is tracked by the level counter.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - show-ahead tagged FIFO with level/flags; TAG_FIFO_STATS_EN adds drop_cnt
module tag_fifo
  import tag_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       w_fifo,
  input  logic [4:0]                 upr,
  input  logic [DATA_W-1:0]          din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       tag_err,
  input  logic                       clr_err
`ifdef TAG_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = TAG_W + DATA_W;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          ovf_drop;
  logic          tag_drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  generate
    if (TAG_W < UPR_VALID_BIT) begin : g_unused_upr
      logic unused_upr_bits;
      assign unused_upr_bits = ^upr[UPR_VALID_BIT-1:TAG_W];
    end
  endgenerate

  assign push_req = w_fifo & upr[UPR_VALID_BIT];
  assign tag_drop = w_fifo & ~upr[UPR_VALID_BIT];
  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign out_valid = ~empty;
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_drop = push_req & full & ~pop;
  assign wr_entry = {upr[TAG_W-1:0], din};

  tag_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr),
    .rdata (rd_entry)
  );

  assign out_tag  = empty ? '0 : rd_entry[EW-1:DATA_W];
  assign out_data = empty ? '0 : rd_entry[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!res) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      ovf     <= 1'b0;
      tag_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Set has priority over clear.
      ovf     <= ovf_drop | (ovf & ~clr_err);
      tag_err <= tag_drop | (tag_err & ~clr_err);
    end
  end

`ifdef TAG_FIFO_STATS_EN
  logic drop_ev;
  assign drop_ev = ovf_drop | tag_drop;

  always_ff @(posedge clk) begin
    if (!res) begin
      drop_cnt <= '0;
    end else if (clr_err) begin
      drop_cnt <= drop_ev ? DROP_CNT_W'(1) : '0;
    end else if (drop_ev) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_tag_fifo.sv
// tb/tb_tag_fifo.sv - self-checking bench for tag_fifo (table, directed and random vs queue model)
module tb_tag_fifo;
  import tag_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       w_fifo = 1'b0;
  logic [4:0] upr = '0;
  logic [7:0] din = '0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_tag;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       tag_err;
`ifdef TAG_FIFO_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  entry_t mq[$];
  bit     m_ovf;
  bit     m_te;
  int     m_drop;

  tag_fifo dut (
    .clk       (clk),
    .res       (res),
    .w_fifo    (w_fifo),
    .upr       (upr),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .tag_err   (tag_err),
    .clr_err   (clr_err)
`ifdef TAG_FIFO_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_model(input bit w, input logic [4:0] u, input logic [7:0] d,
                            input bit rdy, input bit clr, input bit rs);
    bit p, preq, was_full, acc, ovfev, teev;
    entry_t e;
    if (!rs) begin
      mq.delete();
      m_ovf = 0; m_te = 0; m_drop = 0;
      return;
    end
    p        = (mq.size() > 0) && rdy;
    preq     = w && u[4];
    was_full = (mq.size() == 8);
    acc      = preq && (!was_full || p);
    ovfev    = preq && was_full && !p;
    teev     = w && !u[4];
    if (p) void'(mq.pop_front());
    if (acc) begin
      e.tag = u[2:0];
      e.data = d;
      mq.push_back(e);
    end
    m_ovf = ovfev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_te  = teev  ? 1'b1 : (clr ? 1'b0 : m_te);
    if (clr) m_drop = (ovfev || teev) ? 1 : 0;
    else if ((ovfev || teev) && m_drop < 255) m_drop++;
  endtask

  task automatic check_model();
    chk("m_level", 32'(level), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == 8));
    chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0].data) : 32'h0);
    chk("m_tag", 32'(out_tag), (mq.size() != 0) ? 32'(mq[0].tag) : 32'h0);
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
    chk("m_tag_err", 32'(tag_err), 32'(m_te));
`ifdef TAG_FIFO_STATS_EN
    chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  task automatic drive(input bit w, input logic [4:0] u, input logic [7:0] d,
                       input bit rdy, input bit clr, input bit rs);
    w_fifo = w; upr = u; din = d; out_ready = rdy; clr_err = clr; res = rs;
    @(posedge clk);
    step_model(w, u, d, rdy, clr, rs);
    #1;
    check_model();
  endtask

  task automatic idle();
    drive(0, 5'h00, 8'h00, 0, 0, 1);
  endtask

  typedef struct {
    bit         w;
    logic [4:0] u;
    logic [7:0] d;
    bit         rdy;
    bit         clr;
    bit         rs;
    int         e_level;
    bit         e_valid;
    logic [7:0] e_data;
    logic [2:0] e_tag;
    bit         e_te;
    bit         e_ovf;
    int         e_drop;
  } vec_t;

  function automatic vec_t mk(bit w, logic [4:0] u, logic [7:0] d, bit rdy, bit clr, bit rs,
                              int el, bit ev, logic [7:0] ed, logic [2:0] et, bit ete,
                              bit eo, int edr);
    vec_t v;
    v.w = w; v.u = u; v.d = d; v.rdy = rdy; v.clr = clr; v.rs = rs;
    v.e_level = el; v.e_valid = ev; v.e_data = ed; v.e_tag = et;
    v.e_te = ete; v.e_ovf = eo; v.e_drop = edr;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5'h12, 8'h3C, 0, 0, 1, 1, 1, 8'h3C, 2, 0, 0, 0);
    tbl[2]  = mk(0, 5'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 5'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[4]  = mk(1, 5'h03, 8'h77, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1);
    tbl[5]  = mk(0, 5'h00, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[6]  = mk(1, 5'h01, 8'h11, 0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 1);
    tbl[7]  = mk(0, 5'h00, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[8]  = mk(1, 5'h11, 8'hA1, 0, 0, 1, 1, 1, 8'hA1, 1, 0, 0, 0);
    tbl[9]  = mk(1, 5'h12, 8'hA2, 1, 0, 1, 1, 1, 8'hA2, 2, 0, 0, 0);
    tbl[10] = mk(1, 5'h13, 8'hA3, 0, 0, 1, 2, 1, 8'hA2, 2, 0, 0, 0);
    tbl[11] = mk(1, 5'h14, 8'hA4, 0, 0, 1, 3, 1, 8'hA2, 2, 0, 0, 0);
    tbl[12] = mk(0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[13] = mk(1, 5'h16, 8'h9E, 0, 0, 1, 1, 1, 8'h9E, 6, 0, 0, 0);
    tbl[14] = mk(0, 5'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);

    drive(0, 5'h00, 8'h00, 0, 0, 0);
    drive(0, 5'h00, 8'h00, 0, 0, 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'({ovf, tag_err}), 0);
    chk("rst_head", 32'({out_tag, out_data}), 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].w, tbl[i].u, tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].rs);
      chk($sformatf("t%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("t%0d_head", i), 32'({out_tag, out_data}), 32'({tbl[i].e_tag, tbl[i].e_data}));
      chk($sformatf("t%0d_flags", i), 32'({tag_err, ovf}), 32'({tbl[i].e_te, tbl[i].e_ovf}));
`ifdef TAG_FIFO_STATS_EN
      chk($sformatf("t%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
`endif
    end

    // Fill, overflow, drain in order.
    for (int i = 0; i < 8; i++) drive(1, 5'h10 | 5'(i), 8'h10 + 8'(i), 0, 0, 1);
    idle();
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 8);
    chk("fill_head", 32'({out_tag, out_data}), 32'({3'd0, 8'h10}));
    chk("fill_ovf", 32'(ovf), 0);
    drive(1, 5'h10, 8'hAA, 0, 0, 1);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'({out_tag, out_data}), 32'({3'(i), 8'h10 + 8'(i)}));
      drive(0, 5'h00, 8'h00, 1, 0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf_sticky", 32'(ovf), 1);
    drive(0, 5'h00, 8'h00, 0, 1, 1);
    chk("ovf_clr", 32'(ovf), 0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) drive(1, 5'h10 | 5'(i), 8'h20 + 8'(i), 0, 0, 1);
    drive(1, 5'h15, 8'h55, 1, 0, 1);
    chk("pp_level", 32'(level), 8);
    chk("pp_ovf", 32'(ovf), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain%0d", i), 32'(out_data), (i < 7) ? 32'(8'h21 + 8'(i)) : 32'h55);
      drive(0, 5'h00, 8'h00, 1, 0, 1);
    end
    chk("pp_empty", 32'(empty), 1);

    // Randomised traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 60, 5'($urandom), 8'($urandom),
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
